frequency_counter_gate: RTL and testbench
=========================================

// Module: frequency_counter_gate
// PURPOSE
//  Measurement datapath that feeds frequency_counter_control. Counts rising edges of the
//  external signal Sig during a gate window sized by std_f_sel, latches the result, and
//  reports out-of-range results on Cntover/Cntlow. The controller uses these flags to step
//  range/std_f_sel, then restarts a measurement with its reset output.
// PARAMETERS
//  CNT_W       16    edge-counter / Count width
//  GATE_W      24    gate-timer width; GATE_BASE<<9 must fit
//  GATE_BASE   100   gate length in Clk cycles for std_f_sel=0
//  HI_TH       9999  Cntover when count > HI_TH
//  LO_TH       1000  Cntlow when count < LO_TH
//  HOLD_CYCLES 16    idle cycles between auto-run gates (FREQ_GATE_AUTORUN_EN only)
// PORTS
//  Clk        in   1      system clock, all logic on rising edge
//  Clear      in   1      asynchronous active-high reset
//  reset      in   1      synchronous restart from controller; level, active-high
//  std_f_sel  in   2      gate select, sampled at gate start
//  Sig        in   1      measured signal, asynchronous to Clk
//  Count      out  CNT_W  latched edge count of last completed gate
//  Valid      out  1      one-cycle pulse when Count/flags update
//  Cntover    out  1      last result above range (held)
//  Cntlow     out  1      last result below range (held)
//  busy       out  1      high while in GATE or EVAL
// BEHAVIOUR
//  - Clear: all flops to 0, state IDLE. Outputs Count=0, Valid=0, Cntover=0, Cntlow=0, busy=0.
//  - Sig passes a 2-FF synchroniser, then a registered rising-edge detect. An edge counts
//    3 Clk after the Sig transition. Sig high time and low time must each be >=2 Clk.
//  - Gate length Tg = GATE_BASE << (3*std_f_sel) cycles: 100/800/6400/51200 by default.
//  - FSM IDLE -> GATE -> EVAL -> DONE:
//    IDLE: leave on reset=1. Go to GATE next cycle.
//    GATE: on entry, load the timer with Tg-1, clear the counter, latch std_f_sel, busy=1.
//      Count detected edges for exactly Tg cycles. Go to EVAL when timer==0.
//    EVAL: one cycle. Latch Count. Cntover=(cnt>HI_TH)|sat. Cntlow=~Cntover&(cnt<LO_TH).
//      Go to DONE. Valid pulses in the first DONE cycle.
//    DONE: hold outputs. reset=1 goes to GATE. Flags stay valid until the next EVAL.
//  - reset=1 in GATE or EVAL aborts. The gate restarts, counter and timer reload, and no
//    Valid is issued. A reset held high keeps restarting, so a gate completes only after
//    reset falls.
//  - Counter saturates at 2^CNT_W-1 and sets a sticky sat bit for the gate. No wrap.
//  - Boundaries: cnt==HI_TH gives no Cntover. cnt==LO_TH gives no Cntlow. Cntover and
//    Cntlow are never both 1.
//  - An edge detected on the last GATE cycle is counted. An edge in EVAL or DONE is dropped.
//  - Clear mid-gate returns to IDLE immediately; any partial count is discarded.
// CONFIGURATION
//  FREQ_GATE_AUTORUN_EN defined: DONE waits HOLD_CYCLES cycles, then re-enters GATE without
//    reset (continuous measurement). reset still restarts immediately.
//  Undefined: DONE holds indefinitely until reset; HOLD_CYCLES is unused.
// TESTING (bench: GATE_BASE=100, LO_TH=10, HI_TH=50, CNT_W=8)
//  1. Clear pulse -> all outputs 0, busy=0, state IDLE; Sig toggling has no effect.
//  2. sel=0, Sig period 4 Clk, reset 1 cycle -> busy for 101 cycles; Count=25, Valid 1 cycle,
//     Cntover=0, Cntlow=0.
//  3. sel=0, Sig period 40 Clk -> Count=2 or 3 depending on phase, Cntlow=1, Cntover=0.
//  4. sel=1 (800 cyc), Sig period 4 -> true count 200 within CNT_W, Count=200, Cntover=1;
//     sel=2, period 4 -> Count=255 saturated, Cntover=1.
//  5. reset re-asserted 50 cycles into gate -> no Valid; next Valid arrives 101 cycles after
//     the restart with a full-gate Count.
//  6. FREQ_GATE_AUTORUN_EN, HOLD_CYCLES=16, one reset -> Valid repeats every 118 cycles
//     (GATE 100 + EVAL 1 + DONE 17) with a constant Count.

Source files
------------

// File: rtl/frequency_counter_gate.sv
// -----------------------------------------------------------------------------
// frequency_counter_gate
//   Measurement datapath for frequency_counter_control. Counts rising edges of
//   the asynchronous input Sig over a gate window of GATE_BASE << (3*std_f_sel)
//   Clk cycles, latches the result and flags results above/below range.
//
// Ports
//   Clk        in   1      system clock, rising edge
//   Clear      in   1      asynchronous active-high reset
//   reset      in   1      synchronous restart (level, active-high)
//   std_f_sel  in   2      gate select, sampled when a gate starts
//   Sig        in   1      measured signal, asynchronous to Clk
//   Count      out  CNT_W  edge count of the last completed gate
//   Valid      out  1      one-cycle pulse when Count/flags update
//   Cntover    out  1      last result above HI_TH (or saturated)
//   Cntlow     out  1      last result below LO_TH
//   busy       out  1      high while in GATE or EVAL
//
// Build option
//   FREQ_GATE_AUTORUN_EN : when defined, DONE waits HOLD_CYCLES cycles and then
//   starts the next gate on its own. Otherwise DONE holds until reset.
// -----------------------------------------------------------------------------
module frequency_counter_gate #(
    parameter int CNT_W       = 16,
    parameter int GATE_W      = 24,
    parameter int GATE_BASE   = 100,
    parameter int HI_TH       = 9999,
    parameter int LO_TH       = 1000,
    parameter int HOLD_CYCLES = 16
) (
    input  logic             Clk,
    input  logic             Clear,
    input  logic             reset,
    input  logic [1:0]       std_f_sel,
    input  logic             Sig,
    output logic [CNT_W-1:0] Count,
    output logic             Valid,
    output logic             Cntover,
    output logic             Cntlow,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GATE = 2'd1,
        S_EVAL = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam int unsigned HI_U    = HI_TH;
    localparam int unsigned LO_U    = LO_TH;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             state_q, state_d;
    logic [GATE_W-1:0]  timer_q, timer_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sat_q, sat_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               over_q, over_d;
    logic               low_q, low_d;
    logic               valid_q, valid_d;
    logic               sync1_q, sync1_d;
    logic               sync2_q, sync2_d;
    logic               sync3_q, sync3_d;
    logic               edge_q, edge_d;

`ifdef FREQ_GATE_AUTORUN_EN
    localparam int HOLD_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    logic [HOLD_W-1:0]  hold_q, hold_d;
`endif

    // Gate length minus one for the selection present at gate start. The
    // timer itself is the captured copy of the selection for this gate.
    logic [GATE_W-1:0] gate_base;
    logic [GATE_W-1:0] gate_load;
    logic              start;
    logic              eval_over;

    assign gate_base = GATE_W'(GATE_BASE);

    always_comb begin
        gate_load = gate_base - GATE_W'(1);
        case (std_f_sel)
            2'd0:    gate_load = gate_base - GATE_W'(1);
            2'd1:    gate_load = (gate_base << 3) - GATE_W'(1);
            2'd2:    gate_load = (gate_base << 6) - GATE_W'(1);
            default: gate_load = (gate_base << 9) - GATE_W'(1);
        endcase
    end

    // Sig -> two-flop synchroniser -> delayed copy -> registered rise detect.
    always_comb begin
        sync1_d = Sig;
        sync2_d = sync1_q;
        sync3_d = sync2_q;
        edge_d  = sync2_q & ~sync3_q;
    end

    assign eval_over = (32'(cnt_q) > HI_U) | sat_q;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        count_d = count_q;
        over_d  = over_q;
        low_d   = low_q;
        valid_d = 1'b0;
        start   = 1'b0;
`ifdef FREQ_GATE_AUTORUN_EN
        hold_d  = hold_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (reset) start = 1'b1;
            end
            S_GATE: begin
                if (reset) begin
                    start = 1'b1;
                end else begin
                    // Edge on the final gate cycle still lands in cnt_q
                    // before EVAL samples it.
                    if (edge_q) begin
                        if (cnt_q == CNT_MAX) sat_d = 1'b1;
                        else                  cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (timer_q == '0) state_d = S_EVAL;
                    else               timer_d = timer_q - GATE_W'(1);
                end
            end
            S_EVAL: begin
                if (reset) begin
                    start = 1'b1;
                end else begin
                    count_d = cnt_q;
                    over_d  = eval_over;
                    low_d   = ~eval_over & (32'(cnt_q) < LO_U);
                    valid_d = 1'b1;
                    state_d = S_DONE;
`ifdef FREQ_GATE_AUTORUN_EN
                    hold_d  = '0;
`endif
                end
            end
            S_DONE: begin
                if (reset) begin
                    start = 1'b1;
                end
`ifdef FREQ_GATE_AUTORUN_EN
                // DONE lasts HOLD_CYCLES+1 cycles before the next gate.
                else if (hold_q == HOLD_W'(HOLD_CYCLES)) begin
                    start = 1'b1;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase

        // Any gate start (first, restart, abort, auto-run) reloads everything.
        if (start) begin
            state_d = S_GATE;
            timer_d = gate_load;
            cnt_d   = '0;
            sat_d   = 1'b0;
            valid_d = 1'b0;
`ifdef FREQ_GATE_AUTORUN_EN
            hold_d  = '0;
`endif
        end
    end

    always_ff @(posedge Clk or posedge Clear) begin
        if (Clear) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            count_q <= '0;
            over_q  <= 1'b0;
            low_q   <= 1'b0;
            valid_q <= 1'b0;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
            edge_q  <= 1'b0;
`ifdef FREQ_GATE_AUTORUN_EN
            hold_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            count_q <= count_d;
            over_q  <= over_d;
            low_q   <= low_d;
            valid_q <= valid_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            sync3_q <= sync3_d;
            edge_q  <= edge_d;
`ifdef FREQ_GATE_AUTORUN_EN
            hold_q  <= hold_d;
`endif
        end
    end

    assign Count   = count_q;
    assign Valid   = valid_q;
    assign Cntover = over_q;
    assign Cntlow  = low_q;
    assign busy    = (state_q == S_GATE) || (state_q == S_EVAL);

endmodule

// File: tb/tb_frequency_counter_gate.sv
module tb_frequency_counter_gate;

    localparam int CNT_W = 8;

    logic             Clk = 1'b0;
    logic             Clear = 1'b1;
    logic             reset = 1'b0;
    logic [1:0]       std_f_sel = 2'd0;
    logic             Sig = 1'b0;
    logic [CNT_W-1:0] Count;
    logic             Valid, Cntover, Cntlow, busy;

    frequency_counter_gate #(
        .CNT_W(CNT_W), .GATE_W(24), .GATE_BASE(100),
        .HI_TH(50), .LO_TH(10), .HOLD_CYCLES(16)
    ) dut (
        .Clk(Clk), .Clear(Clear), .reset(reset), .std_f_sel(std_f_sel),
        .Sig(Sig), .Count(Count), .Valid(Valid), .Cntover(Cntover),
        .Cntlow(Cntlow), .busy(busy)
    );

    always #5 Clk = ~Clk;

    // Sig generator: period sig_per Clk cycles, 50% duty; <2 means held low.
    int sig_per = 0;
    int sig_ph  = 0;
    always @(negedge Clk) begin
        if (sig_per < 2) begin
            Sig = 1'b0;
            sig_ph = 0;
        end else begin
            sig_ph = (sig_ph + 1) % sig_per;
            Sig = (sig_ph < sig_per / 2);
        end
    end

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
        n_tot++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
    endtask

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic pulse_reset;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Ticks until Valid is seen; lat = edges from the sampling edge of the
    // restart to the edge that raised Valid. Bounded; -1 on timeout.
    task automatic wait_valid(input int limit, output int lat, output int busy_n);
        lat = -1;
        busy_n = 0;
        for (int i = 1; i <= limit; i++) begin
            if (busy) busy_n++;
            tick();
            if (Valid) begin
                lat = i;
                break;
            end
        end
    endtask

    typedef struct {
        string nm;
        int    sel;
        int    per;
        int    cnt_lo;
        int    cnt_hi;
        int    over;
        int    low;
        int    lat;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int lat, bn, nv, nb;

        vecs[0] = '{"sel0_p4",     0, 4,  25,  25,  0, 0, 101};
        vecs[1] = '{"sel0_p40",    0, 40, 2,   3,   0, 1, 101};
        vecs[2] = '{"sel1_p4",     1, 4,  200, 200, 1, 0, 801};
        vecs[3] = '{"sel2_p4_sat", 2, 4,  255, 255, 1, 0, 6401};
        vecs[4] = '{"sel0_p8",     0, 8,  12,  13,  0, 0, 101};
        vecs[5] = '{"sel0_idle",   0, 0,  0,   0,   0, 1, 101};
        vecs[6] = '{"lo_edge_10",  0, 10, 10,  10,  0, 0, 101};
        vecs[7] = '{"hi_edge_50",  1, 16, 50,  50,  0, 0, 801};
        vecs[8] = '{"above_hi",    1, 15, 53,  54,  1, 0, 801};

        // Clear: everything zero, Sig activity alone starts nothing.
        repeat (3) tick();
        chk("clr_count", int'(Count), 0);
        chk("clr_valid", int'(Valid), 0);
        chk("clr_over",  int'(Cntover), 0);
        chk("clr_low",   int'(Cntlow), 0);
        chk("clr_busy",  int'(busy), 0);
        Clear = 1'b0;
        sig_per = 4;
        nv = 0; nb = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (Valid) nv++;
            if (busy) nb++;
        end
        chk("idle_no_valid", nv, 0);
        chk("idle_no_busy",  nb, 0);
        chk("idle_count",    int'(Count), 0);

        // Table-driven measurements.
        foreach (vecs[k]) begin
            std_f_sel = 2'(vecs[k].sel);
            sig_per = vecs[k].per;
            repeat (8) tick();
            pulse_reset();
            wait_valid(vecs[k].lat + 50, lat, bn);
            chk({vecs[k].nm, "_lat"}, lat, vecs[k].lat);
            chk({vecs[k].nm, "_busy"}, bn, vecs[k].lat);
            chk_rng({vecs[k].nm, "_count"}, int'(Count), vecs[k].cnt_lo, vecs[k].cnt_hi);
            chk({vecs[k].nm, "_over"}, int'(Cntover), vecs[k].over);
            chk({vecs[k].nm, "_low"}, int'(Cntlow), vecs[k].low);
            tick();
            chk({vecs[k].nm, "_vpulse"}, int'(Valid), 0);
            chk({vecs[k].nm, "_hold_cnt"}, int'(Count) >= vecs[k].cnt_lo && int'(Count) <= vecs[k].cnt_hi, 1);
        end

        // Abort 50 cycles into a gate: no Valid, full gate after restart.
        std_f_sel = 2'd0;
        sig_per = 4;
        repeat (8) tick();
        pulse_reset();
        nv = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (Valid) nv++;
        end
        chk("abort_no_valid", nv, 0);
        pulse_reset();
        wait_valid(200, lat, bn);
        chk("abort_lat", lat, 101);
        chk("abort_count", int'(Count), 25);

        // Restart arriving exactly in EVAL: no Valid for the aborted gate.
        pulse_reset();
        repeat (100) tick();
        chk("eval_busy", int'(busy), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("eval_abort_valid", int'(Valid), 0);
        chk("eval_abort_busy", int'(busy), 1);
        wait_valid(200, lat, bn);
        chk("eval_abort_lat", lat, 101);
        chk("eval_abort_count", int'(Count), 25);

        // Reset held high keeps restarting; the gate runs after it falls.
        reset = 1'b1;
        nv = 0;
        for (int i = 0; i < 150; i++) begin
            tick();
            if (Valid) nv++;
        end
        reset = 1'b0;
        chk("held_no_valid", nv, 0);
        wait_valid(200, lat, bn);
        chk("held_lat", lat, 101);
        chk("held_count", int'(Count), 25);

`ifdef FREQ_GATE_AUTORUN_EN
        // Continuous measurement: Valid every 118 cycles, same Count.
        for (int r = 0; r < 2; r++) begin
            wait_valid(300, lat, bn);
            chk("auto_period", lat, 118);
            chk("auto_count", int'(Count), 25);
        end
`else
        // DONE holds without reset.
        nv = 0; nb = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (Valid) nv++;
            if (busy) nb++;
        end
        chk("done_no_valid", nv, 0);
        chk("done_no_busy", nb, 0);
        chk("done_count", int'(Count), 25);
`endif

        // Clear mid-gate after a low-range result: everything drops to zero.
        sig_per = 12;
        repeat (8) tick();
        pulse_reset();
        wait_valid(200, lat, bn);
        chk("pre_clear_low", int'(Cntlow), 1);
        pulse_reset();
        repeat (30) tick();
        Clear = 1'b1;
        #1;
        chk("midclr_busy", int'(busy), 0);
        chk("midclr_count", int'(Count), 0);
        chk("midclr_low", int'(Cntlow), 0);
        tick();
        Clear = 1'b0;
        repeat (150) tick();
        chk("postclr_busy", int'(busy), 0);
        chk("postclr_valid", int'(Valid), 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
